// File: rtl/digit_serial_adder_if.sv
// digit_serial_adder_if
// Handshake and data bundle between a controller and the digit-serial adder.
//   master (controller): drives start, a, b, cin, sub; observes busy, done, s, cout, ovf
//   slave  (adder)     : observes start, a, b, cin, sub; drives busy, done, s, cout, ovf
//   start      request a new operation (honoured only while busy is low)
//   a, b       WIDTH-bit operands
//   cin        carry-in for add, borrow-in for subtract
//   sub        0 = a+b+cin, 1 = a-b-cin
//   busy       operation in progress
//   done       one-cycle pulse, result valid from this cycle
//   s          WIDTH-bit result, held until the next operation completes
//   cout       raw carry out of the MSB (for subtract, 1 means no borrow)
//   ovf        two's-complement signed overflow
interface digit_serial_adder_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;

  modport master (
    output start, a, b, cin, sub,
    input  busy, done, s, cout, ovf
  );

  modport slave (
    input  start, a, b, cin, sub,
    output busy, done, s, cout, ovf
  );
endinterface

// File: rtl/digit_serial_adder.sv
// digit_serial_adder
// Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, least
// significant digit first, using a DIGIT-bit ripple-carry slice and a carry
// register between digits. An operation takes NDIG = WIDTH/DIGIT cycles.
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   digit_serial_adder_if slave modport (start/a/b/cin/sub in,
//         busy/done/s/cout/ovf out)
module digit_serial_adder #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                clk,
  input logic                rst,
  digit_serial_adder_if.slave bus
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CNT_W-1:0] LAST_DIG = CNT_W'(NDIG - 1);

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t state;
  state_t state_next;

  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [CNT_W-1:0] dig_cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] acc_next;

  logic [WIDTH-1:0] s_q;
  logic             cout_q;
  logic             ovf_q;
  logic             done_q;

  logic             accept;
  logic             last_dig;

  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT-1:0] dig_sum;
  logic [DIGIT:0]   chain;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; start is only looked at while idle, so a start during
  // RUN is simply dropped.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    last_dig   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = RUN;
        end
      end
      RUN: begin
        if (dig_cnt == LAST_DIG) begin
          last_dig   = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // One DIGIT-bit ripple slice. chain[DIGIT-1] is the carry into the slice
  // MSB; on the last digit that is the carry into bit WIDTH-1, which the
  // overflow flag needs.
  always_comb begin
    a_dig    = op_a[dig_cnt*DIGIT +: DIGIT];
    b_dig    = op_b[dig_cnt*DIGIT +: DIGIT];
    chain    = '0;
    dig_sum  = '0;
    chain[0] = carry;
    for (int i = 0; i < DIGIT; i++) begin
      dig_sum[i]  = a_dig[i] ^ b_dig[i] ^ chain[i];
      chain[i+1]  = (a_dig[i] & b_dig[i]) | (chain[i] & (a_dig[i] ^ b_dig[i]));
    end
    acc_next = acc;
    acc_next[dig_cnt*DIGIT +: DIGIT] = dig_sum;
  end

  // Datapath. Partial sums build up in acc so s only moves on the done edge.
  // Subtraction stores ~b and an inverted carry-in: a + ~b + ~cin = a - b - cin.
  always_ff @(posedge clk) begin
    if (rst) begin
      op_a    <= '0;
      op_b    <= '0;
      carry   <= 1'b0;
      dig_cnt <= '0;
      acc     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        op_a    <= bus.a;
        op_b    <= bus.sub ? ~bus.b : bus.b;
        carry   <= bus.cin ^ bus.sub;
        dig_cnt <= '0;
        acc     <= '0;
      end else if (state == RUN) begin
        acc   <= acc_next;
        carry <= chain[DIGIT];
        if (last_dig) begin
          dig_cnt <= '0;
          s_q     <= acc_next;
          cout_q  <= chain[DIGIT];
          ovf_q   <= chain[DIGIT-1] ^ chain[DIGIT];
          done_q  <= 1'b1;
        end else begin
          dig_cnt <= dig_cnt + 1'b1;
        end
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.cout = cout_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder
// Self-checking bench for digit_serial_adder. Three builds (DIGIT = 4, 1, 16)
// share one stimulus; directed table and corner sequences target the DIGIT=4
// build, and a random sweep checks all three against a behavioural model.
module tb_digit_serial_adder;

  localparam int WIDTH = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;

  int errors = 0;
  int checks = 0;
  logic [WIDTH-1:0] last_s4;

  digit_serial_adder_if #(.WIDTH(WIDTH)) bus4 ();
  digit_serial_adder_if #(.WIDTH(WIDTH)) bus1 ();
  digit_serial_adder_if #(.WIDTH(WIDTH)) bus16 ();

  assign bus4.start  = start;
  assign bus4.a      = a;
  assign bus4.b      = b;
  assign bus4.cin    = cin;
  assign bus4.sub    = sub;
  assign bus1.start  = start;
  assign bus1.a      = a;
  assign bus1.b      = b;
  assign bus1.cin    = cin;
  assign bus1.sub    = sub;
  assign bus16.start = start;
  assign bus16.a     = a;
  assign bus16.b     = b;
  assign bus16.cin   = cin;
  assign bus16.sub   = sub;

  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(4))  dut4  (.clk(clk), .rst(rst), .bus(bus4));
  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(1))  dut1  (.clk(clk), .rst(rst), .bus(bus1));
  digit_serial_adder #(.WIDTH(WIDTH), .DIGIT(16)) dut16 (.clk(clk), .rst(rst), .bus(bus16));

  typedef struct {
    string      name;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vcin;
    logic        vsub;
    logic [15:0] exp_s;
    logic        exp_cout;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Called at a negedge: presents the operation for one edge, then drops start
  // and scrambles the operands. Returns at the first negedge after acceptance.
  task automatic applyStimulus(input logic [15:0] va, input logic [15:0] vb,
                               input logic vcin, input logic vsub);
    start = 1'b1;
    a     = va;
    b     = vb;
    cin   = vcin;
    sub   = vsub;
    @(negedge clk);
    start = 1'b0;
    a     = ~va;
    b     = vb ^ 16'h5A5A;
    cin   = ~vcin;
    sub   = ~vsub;
  endtask

  // Bounded wait for done on the DIGIT=4 build; n counts negedges after the
  // accepting edge, so done should arrive at n = 4.
  task automatic waitDone4(input string name, output int n);
    int busy_bad;
    int s_bad;
    busy_bad = 0;
    s_bad    = 0;
    n        = 0;
    while (bus4.done !== 1'b1 && n < 20) begin
      if (bus4.busy !== 1'b1) busy_bad++;
      if (bus4.s !== last_s4) s_bad++;
      @(negedge clk);
      n++;
    end
    checkOutput({name, " busy during run"}, busy_bad, 0);
    checkOutput({name, " s held before done"}, s_bad, 0);
  endtask

  task automatic runOp4(input vec_t v);
    int n;
    applyStimulus(v.va, v.vb, v.vcin, v.vsub);
    waitDone4(v.name, n);
    checkOutput({v.name, " latency"}, n, 4);
    checkOutput({v.name, " s"}, bus4.s, v.exp_s);
    checkOutput({v.name, " cout"}, bus4.cout, v.exp_cout);
    checkOutput({v.name, " ovf"}, bus4.ovf, v.exp_ovf);
    checkOutput({v.name, " busy at done"}, bus4.busy, 0);
    last_s4 = v.exp_s;
    @(negedge clk);
    checkOutput({v.name, " done single pulse"}, bus4.done, 0);
  endtask

  // Reference: plain integer arithmetic, overflow from operand/result signs.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic su);
    logic [15:0] yy;
    logic [16:0] full;
    logic        v;
    yy   = su ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {16'd0, ci ^ su};
    v    = (x[15] == yy[15]) && (full[15] != x[15]);
    return {full[16], v, full[15:0]};
  endfunction

  initial begin
    int n;
    int m;
    int cnt4, cnt1, cnt16;
    int at4, at1, at16;
    logic [17:0] r4, r1, r16, exp;
    logic [15:0] ra, rb;
    logic rc, rs;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    sub   = 1'b0;
    last_s4 = '0;

    vecs[0] = '{"add",        16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0};
    vecs[1] = '{"wrap",       16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vecs[2] = '{"pos ovf",    16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vecs[3] = '{"sub neg",    16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vecs[4] = '{"sub ovf",    16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vecs[5] = '{"sub borrow", 16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000C, 1'b1, 1'b0};
    vecs[6] = '{"neg ovf",    16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vecs[7] = '{"add cin",    16'h00FF, 16'h0001, 1'b1, 1'b0, 16'h0101, 1'b0, 1'b0};

    repeat (2) @(negedge clk);
    checkOutput("reset busy", bus4.busy, 0);
    checkOutput("reset done", bus4.done, 0);
    checkOutput("reset s", bus4.s, 0);
    checkOutput("reset cout", bus4.cout, 0);
    checkOutput("reset ovf", bus4.ovf, 0);
    checkOutput("reset d1/d16 busy", {bus1.busy, bus16.busy}, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) runOp4(vecs[i]);

    // Second start two cycles into RUN must be ignored.
    applyStimulus(16'hFFFF, 16'h0002, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1;
    a     = 16'h0F0F;
    b     = 16'h0F0F;
    cin   = 1'b0;
    sub   = 1'b0;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ignored start s held", bus4.s, last_s4);
    checkOutput("ignored start busy", bus4.busy, 1);
    @(negedge clk);
    checkOutput("ignored start done", bus4.done, 1);
    checkOutput("ignored start s", bus4.s, 16'h0001);
    checkOutput("ignored start cout", bus4.cout, 1);
    last_s4 = 16'h0001;
    m = 0;
    repeat (8) begin
      @(negedge clk);
      if (bus4.done === 1'b1) m++;
    end
    checkOutput("ignored start extra done", m, 0);

    // Reset during RUN aborts and clears the outputs.
    applyStimulus(16'h1000, 16'h0234, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("mid reset busy", bus4.busy, 0);
    checkOutput("mid reset s", bus4.s, 0);
    checkOutput("mid reset cout", bus4.cout, 0);
    checkOutput("mid reset ovf", bus4.ovf, 0);
    m = 0;
    repeat (8) begin
      if (bus4.done === 1'b1) m++;
      @(negedge clk);
    end
    checkOutput("mid reset no done", m, 0);
    last_s4 = '0;

    // Start held in the done cycle is accepted; next done 5 cycles later.
    applyStimulus(16'h1234, 16'h4321, 1'b0, 1'b0);
    waitDone4("b2b first", n);
    checkOutput("b2b first latency", n, 4);
    checkOutput("b2b first s", bus4.s, 16'h5555);
    last_s4 = 16'h5555;
    applyStimulus(16'h00FF, 16'h0001, 1'b0, 1'b0);
    m = 1;
    while (bus4.done !== 1'b1 && m < 20) begin
      @(negedge clk);
      m++;
    end
    checkOutput("b2b spacing", m, 5);
    checkOutput("b2b second s", bus4.s, 16'h0100);
    @(negedge clk);

    // Random sweep over all three builds.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 1000; i++) begin
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rc  = 1'($urandom_range(1));
      rs  = 1'($urandom_range(1));
      exp = model(ra, rb, rc, rs);
      cnt4 = 0; cnt1 = 0; cnt16 = 0;
      at4 = -1; at1 = -1; at16 = -1;
      r4 = '0; r1 = '0; r16 = '0;
      applyStimulus(ra, rb, rc, rs);
      for (int k = 0; k < 20; k++) begin
        if (bus4.done === 1'b1) begin cnt4++; at4 = k; r4 = {bus4.cout, bus4.ovf, bus4.s}; end
        if (bus1.done === 1'b1) begin cnt1++; at1 = k; r1 = {bus1.cout, bus1.ovf, bus1.s}; end
        if (bus16.done === 1'b1) begin cnt16++; at16 = k; r16 = {bus16.cout, bus16.ovf, bus16.s}; end
        @(negedge clk);
      end
      checkOutput($sformatf("sweep %0d D4 result", i), r4, exp);
      checkOutput($sformatf("sweep %0d D1 result", i), r1, exp);
      checkOutput($sformatf("sweep %0d D16 result", i), r16, exp);
      checkOutput($sformatf("sweep %0d D4 done", i), (cnt4 == 1) ? at4 : 99, 4);
      checkOutput($sformatf("sweep %0d D1 done", i), (cnt1 == 1) ? at1 : 99, 16);
      checkOutput($sformatf("sweep %0d D16 done", i), (cnt16 == 1) ? at16 : 99, 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
Name: digit_serial_adder

Overview:
- Parametrised, multi-cycle successor to the 4-bit ripple-carry adder.
- Adds or subtracts two WIDTH-bit operands DIGIT bits per clock, LSB digit first.
- Each cycle uses a DIGIT-bit ripple-carry slice and a registered carry between digits.
- Used where a full-width combinational carry chain is too slow or too large; start/busy/done handshake to a controller.

Parameters:
- WIDTH, 16, operand and result width in bits; must be a multiple of DIGIT.
- DIGIT, 4, bits processed per clock (1..WIDTH); NDIG = WIDTH/DIGIT cycles per operation.

Ports:
- clk  input  1  rising-edge clock, single clock domain.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new operation; sampled only when idle (busy=0).
- a  input  WIDTH  operand A, captured on an accepted start.
- b  input  WIDTH  operand B, captured on an accepted start.
- cin  input  1  carry-in (add) / borrow-in (sub), captured on an accepted start.
- sub  input  1  0 = a+b+cin; 1 = a-b-cin; captured on an accepted start.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse; s/cout/ovf are valid from this cycle.
- s  output  WIDTH  result, held until the next accepted start completes.
- cout  output  1  raw carry out of the MSB (for sub: 1 = no borrow).
- ovf  output  1  two's-complement signed overflow.

Behaviour:
- Reset: synchronous, active-high.
  - State returns to IDLE.
  - busy=0, done=0, s=0, cout=0, ovf=0.
  - Internal operand, carry and digit-counter registers are cleared.
- States: IDLE, RUN.
- IDLE, start=1: accept the operation.
  - Latch A=a and B = sub ? ~b : b.
  - Set carry register = cin ^ sub (so sub computes a + ~b + ~cin = a-b-cin).
  - Clear the digit counter, go to RUN, busy=1 from the next cycle.
  - s is not cleared on start.
- RUN, each cycle k (0..NDIG-1):
  - Add digit k of A and B plus the carry register.
  - Write the DIGIT-bit sum into result bits [k*DIGIT +: DIGIT].
  - Carry register takes the digit carry-out; the counter increments.
- Last digit (k = NDIG-1):
  - cout = carry out of bit WIDTH-1.
  - ovf = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1.
  - s updates with the complete result; done=1 for exactly one cycle; busy=0; state = IDLE. All take effect on the same edge.
- Latency: start accepted at edge 0 → done high in the cycle after edge NDIG; busy high for NDIG cycles.
- s/cout/ovf change only on the done edge. Partial sums never appear on s: use a separate accumulator register.
- start while busy=1: ignored; no effect on the in-flight operation.
- start in the done cycle: state is IDLE, so it is accepted. Back-to-back throughput is one op per NDIG+1 cycles.
- a/b/cin/sub changing after acceptance: no effect.
- rst during RUN: operation aborted, done never pulses, all outputs go to reset values.
- DIGIT = WIDTH: NDIG = 1, single-cycle registered adder, same handshake.
- Arithmetic is modulo 2^WIDTH; no saturation.

Test Plan (WIDTH=16, DIGIT=4, NDIG=4):
- Add: a=0x1234, b=0x4321, cin=0, sub=0, start pulse → busy for 4 cycles, then done with s=0x5555, cout=0, ovf=0.
- Wrap: a=0xFFFF, b=0x0001, cin=0, sub=0 → s=0x0000, cout=1, ovf=0. Then a=0x7FFF, b=0x0001 → s=0x8000, cout=0, ovf=1.
- Sub: a=0x0005, b=0x0007, cin=0, sub=1 → s=0xFFFE, cout=0, ovf=0.
  - Then a=0x8000, b=0x0001, sub=1 → s=0x7FFF, cout=1, ovf=1.
  - Then a=0x0010, b=0x0003, cin=1, sub=1 → s=0x000C, cout=1.
- Ignored start: second start with different operands two cycles into RUN → single done, result of the first operation only; s unchanged before done.
- Reset mid-op: rst=1 in RUN cycle 2 → next cycle busy=0, s=0, cout=0, ovf=0; done stays 0 for ≥6 cycles.
- Back-to-back: start held in the done cycle with a=0x00FF, b=0x0001 → accepted; next done 5 cycles after the previous one, with s=0x0100.
- Sweep: DIGIT=1 and DIGIT=16 builds, 1000 random a/b/cin/sub vectors checked against a behavioural model, including done timing.
